// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core front end: PC-source
// encodings, fetch FSM states, reset PC and next-PC helper functions.
package cpu_pkg;

  localparam logic [1:0] PC_JUMP = 2'b00;
  localparam logic [1:0] PC_SEQ  = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq   = 2'b00,
    StHold  = 2'b01,
    StFault = 2'b10
  } fetch_state_e;

  // Branch displacement: sign-extended word offset turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // J-type target keeps the 256 MB region of the delay-free PC+4.
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, order hand-off to execute and
// next-PC control coming back from the decoder.
interface inst_fetch_if;

  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] order;
  logic        order_valid;
  logic        order_ready;
  logic [1:0]  pc_sel;
  logic        br_taken;
  logic [31:0] rs_data;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] retired;

  modport master (
    output im_req, im_addr, order, order_valid, pc_plus4, fault, retired,
    input  im_ack, im_rdata, order_ready, pc_sel, br_taken, rs_data
  );

  modport slave (
    input  im_req, im_addr, order, order_valid, pc_plus4, fault, retired,
    output im_ack, im_rdata, order_ready, pc_sel, br_taken, rs_data
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the accept cycle, plus a flag for a
// target that is not word-aligned.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] order_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        br_taken_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] next_pc;

  // Opcode bits are decoded elsewhere; only the immediate fields matter here.
  logic unused_order;
  assign unused_order = ^order_i[31:26];

  always_comb begin
    next_pc = pc_plus4_i;
    unique case (pc_sel_i)
      PC_JUMP: next_pc = jump_target(pc_plus4_i[31:28], order_i[25:0]);
      PC_REG:  next_pc = rs_data_i;
      default: begin
        if (br_taken_i) begin
          next_pc = pc_plus4_i + branch_offset(order_i[15:0]);
        end
      end
    endcase
  end

  assign next_pc_o    = next_pc;
  assign misaligned_o = |next_pc[1:0];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per req/ack, holds it
// for execute and steers to the next PC, latching a sticky fault on misalignment.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master fetch_io
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  order_q, order_d;
  logic [31:0]  retired_q, retired_d;
  logic         fault_q, fault_d;
  logic         started_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         im_req;
  logic         order_valid;
  logic         ack;
  logic         accept;

  assign pc_plus4 = pc_q + 32'd4;

  npc_calc u_npc_calc (
    .pc_plus4_i   (pc_plus4),
    .order_i      (order_q),
    .pc_sel_i     (fetch_io.pc_sel),
    .br_taken_i   (fetch_io.br_taken),
    .rs_data_i    (fetch_io.rs_data),
    .next_pc_o    (next_pc),
    .misaligned_o (misaligned)
  );

  // started_q keeps the request low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      order_q   <= 32'h0;
      retired_q <= 32'h0;
      fault_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      order_q   <= order_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      started_q <= 1'b1;
    end
  end

  assign ack    = im_req & fetch_io.im_ack;
  assign accept = order_valid & fetch_io.order_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: begin
        if (ack) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (accept) begin
          state_d = misaligned ? StFault : StReq;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    order_d   = order_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    if (ack) begin
      order_d = fetch_io.im_rdata;
    end
    if (accept) begin
      retired_d = retired_q + 32'd1;
      if (misaligned) begin
        fault_d = 1'b1;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_comb begin
    im_req      = 1'b0;
    order_valid = 1'b0;
    unique case (state_q)
      StReq:   im_req      = started_q;
      StHold:  order_valid = 1'b1;
      default: ;
    endcase
  end

  assign fetch_io.im_req      = im_req;
  assign fetch_io.im_addr     = pc_q;
  assign fetch_io.order       = order_q;
  assign fetch_io.order_valid = order_valid;
  assign fetch_io.pc_plus4    = pc_plus4;
  assign fetch_io.fault       = fault_q;
  assign fetch_io.retired     = retired_q;

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    im_req |-> (pc_q[1:0] == 2'b00));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a queue of expected fetch addresses is filled
// as instructions are accepted and drained as each new request appears.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_io (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_retired = 32'h0;
  logic [31:0] cur_word = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] word,
                                            input logic [1:0] sel, input logic br,
                                            input logic [31:0] rs);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (sel == 2'b00) return {p4[31:28], word[25:0], 2'b00};
    if (sel == 2'b10) return rs;
    if (br) return p4 + {{14{word[15]}}, word[15:0], 2'b00};
    return p4;
  endfunction

  // Wait for a request, compare its address with the scoreboard, then ack.
  task automatic fetch(input logic [31:0] word, input int delay, output int start_cyc);
    int n;
    logic [31:0] exp;
    n = 0;
    while (bus.im_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", bus.im_req, 1);
    start_cyc = cyc;
    checks++;
    if (exp_addr_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
      exp = model_pc;
    end else begin
      exp = exp_addr_q.pop_front();
    end
    model_pc = exp;
    chk("im_addr", bus.im_addr, exp);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("wait_req", bus.im_req, 1);
      chk("wait_addr", bus.im_addr, exp);
      chk("wait_valid", bus.order_valid, 0);
    end
    bus.im_ack = 1'b1;
    bus.im_rdata = word;
    step();
    bus.im_ack = 1'b0;
    bus.im_rdata = 32'hDEAD_BEEF;
    cur_word = word;
    chk("valid_after_ack", bus.order_valid, 1);
    chk("order", bus.order, word);
    chk("req_in_hold", bus.im_req, 0);
    chk("pc_plus4", bus.pc_plus4, exp + 32'd4);
  endtask

  task automatic accept(input logic [1:0] sel, input logic br, input logic [31:0] rs);
    logic [31:0] npc;
    npc = model_npc(model_pc, cur_word, sel, br, rs);
    bus.pc_sel = sel;
    bus.br_taken = br;
    bus.rs_data = rs;
    bus.order_ready = 1'b1;
    step();
    bus.order_ready = 1'b0;
    model_retired = model_retired + 32'd1;
    chk("retired", bus.retired, model_retired);
    if (npc[1:0] != 2'b00) begin
      chk("fault_set", bus.fault, 1);
    end else begin
      chk("fault_clear", bus.fault, 0);
      exp_addr_q.push_back(npc);
    end
  endtask

  int c0, c1, c2;

  initial begin
    bus.im_ack = 1'b0;
    bus.im_rdata = 32'h0;
    bus.order_ready = 1'b0;
    bus.pc_sel = PC_SEQ;
    bus.br_taken = 1'b0;
    bus.rs_data = 32'h0;

    // Reset values
    #12;
    chk("rst_req", bus.im_req, 0);
    chk("rst_addr", bus.im_addr, 32'h0);
    chk("rst_order", bus.order, 32'h0);
    chk("rst_valid", bus.order_valid, 0);
    chk("rst_pc_plus4", bus.pc_plus4, 32'h4);
    chk("rst_fault", bus.fault, 0);
    chk("rst_retired", bus.retired, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("req_before_edge", bus.im_req, 0);
    step();
    chk("req_after_edge", bus.im_req, 1);
    exp_addr_q.push_back(32'h0);

    // Sequential fetch at full rate
    fetch(32'h2000_0001, 0, c0);
    accept(PC_SEQ, 1'b0, 32'h0);
    fetch(32'h2000_0002, 0, c1);
    chk("throughput_1", c1 - c0, 2);
    accept(PC_SEQ, 1'b0, 32'h0);
    fetch(32'h2000_0003, 0, c2);
    chk("throughput_2", c2 - c1, 2);
    accept(PC_SEQ, 1'b0, 32'h0);
    chk("retired_3", bus.retired, 32'd3);

    // Slow memory at 0xC, then jr to 0x100
    fetch(32'h0000_0008, 3, c0);
    accept(PC_REG, 1'b0, 32'h100);

    // Branch taken and not taken from 0x100
    fetch(32'h1000_FFFE, 0, c0);
    accept(PC_SEQ, 1'b1, 32'h0);
    fetch(32'h0000_0008, 0, c0);
    accept(PC_REG, 1'b0, 32'h100);
    fetch(32'h1000_FFFE, 0, c0);
    accept(2'b11, 1'b0, 32'h0);

    // Jump and jr
    fetch(32'h0000_0008, 0, c0);
    accept(PC_REG, 1'b0, 32'h8000_0010);
    fetch(32'h0800_0040, 0, c0);
    accept(PC_JUMP, 1'b0, 32'h0);
    fetch(32'h0000_0008, 0, c0);
    accept(PC_REG, 1'b0, 32'h200);

    // PC wrap
    fetch(32'h0000_0008, 0, c0);
    accept(PC_REG, 1'b0, 32'hFFFF_FFFC);
    fetch(32'h2000_00AA, 0, c0);
    chk("wrap_pc_plus4", bus.pc_plus4, 32'h0);
    accept(PC_SEQ, 1'b0, 32'h0);

    // Stall then misaligned jr
    fetch(32'h0000_0008, 0, c0);
    for (int i = 0; i < 5; i++) begin
      bus.im_ack = 1'b1;
      step();
      chk("stall_order", bus.order, 32'h0000_0008);
      chk("stall_valid", bus.order_valid, 1);
      chk("stall_req", bus.im_req, 0);
    end
    bus.im_ack = 1'b0;
    accept(PC_REG, 1'b0, 32'h202);
    chk("fault_req", bus.im_req, 0);
    chk("fault_valid", bus.order_valid, 0);
    bus.im_ack = 1'b1;
    bus.order_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_sticky", bus.fault, 1);
      chk("fault_no_req", bus.im_req, 0);
      chk("fault_retired", bus.retired, model_retired);
      chk("fault_order", bus.order, 32'h0000_0008);
    end
    bus.im_ack = 1'b0;
    bus.order_ready = 1'b0;

    // Async reset mid-request, then a stray ack on the first edge is ignored
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("rereq", bus.im_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_drop_req", bus.im_req, 0);
    chk("async_fault", bus.fault, 0);
    chk("async_retired", bus.retired, 32'h0);
    step();
    bus.im_ack = 1'b1;
    bus.im_rdata = 32'h1234_5678;
    rst_n = 1'b1;
    step();
    bus.im_ack = 1'b0;
    chk("late_ack_valid", bus.order_valid, 0);
    chk("late_ack_order", bus.order, 32'h0);
    chk("late_ack_req", bus.im_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the 32-bit single-cycle MIPS core. It holds the program counter and fetches one instruction word at a time from instruction memory over a req/ack handshake. It presents the word as `order` to the control decoder and datapath, and computes the next PC from the decoder's PC-source select, the branch-taken flag and the register operand once the word is accepted. It replaces the free-running `PC_CLK` register and the constant `IM_R` read enable.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `im_req`  out  1: instruction-memory read request.
- `im_addr`  out  32: byte address of the request; always word-aligned.
- `im_ack`  in  1: memory returns data this cycle; sampled only while `im_req`=1.
- `im_rdata`  in  32: instruction word, valid with `im_ack`.
- `order`  out  32: current instruction to the decoder.
- `order_valid`  out  1: `order` holds a fetched instruction.
- `order_ready`  in  1: execute consumes `order` this cycle.
- `pc_sel`  in  2: next-PC source from the decoder. 00 = jump target, 01 = sequential/branch, 10 = `rs_data`, 11 = treated as 01.
- `br_taken`  in  1: conditional branch taken; used only when `pc_sel`=01.
- `rs_data`  in  32: register operand for `jr`.
- `pc_plus4`  out  32: PC+4 of the current `order`; the link value for `jal`.
- `fault`  out  1: sticky misaligned-target flag.
- `retired`  out  32: count of accepted instructions; wraps at 2^32.

## Operation
- The FSM has three states: `REQ`, `HOLD`, `FAULT`. Reset enters `REQ` with `pc`=`RESET_PC`.
- `REQ`:
  - `im_req`=1, `im_addr`=`pc`; both are held stable until the request is acked.
  - On `im_ack`: `order`<=`im_rdata`, go to `HOLD`.
- `HOLD`:
  - `order_valid`=1 and `order` is stable.
  - On `order_ready`, compute `next_pc`, increment `retired`, then:
    - if `next_pc[1:0]`≠0: `fault`<=1, go to `FAULT`;
    - otherwise `pc`<=`next_pc`, go to `REQ`.
- `next_pc` by `pc_sel`:
  - 00: {`pc_plus4[31:28]`, `order[25:0]`, 2'b00}.
  - 10: `rs_data`.
  - 01/11 with `br_taken`=1: `pc_plus4` + (sign-extended `order[15:0]` << 2).
  - 01/11 with `br_taken`=0: `pc_plus4`.
- All arithmetic is modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0 with no fault.
- `FAULT`: `im_req`=0 and `order_valid`=0. The block stays there until reset. `order` keeps the faulting instruction.
- `im_ack` while `im_req`=0 is ignored. `order_ready` outside `HOLD` is ignored.

## Timing
- Reset values: `im_req`=0 while `rst_n` is low, then 1 from the first clock edge after release. `im_addr`=`RESET_PC`, `order`=0, `order_valid`=0, `pc_plus4`=`RESET_PC`+4, `fault`=0, `retired`=0.
- All outputs are registered or decoded from registered state. `next_pc` is combinational from `order`, `pc_sel`, `br_taken` and `rs_data` in the accept cycle only.
- `im_ack` may arrive in the first `REQ` cycle, or any number of cycles later.
- Minimum throughput: REQ and HOLD each take one cycle, so 2 cycles per instruction.
- Latency: from acceptance edge to new `im_addr` is 1 cycle. From `im_ack` edge to `order_valid` is 1 cycle.
- Asserting `rst_n` mid-request drops `im_req` immediately. Instruction memory must tolerate the abandoned request; any late ack is ignored.

## Structure
- Shared package `cpu_pkg`:
  - `pc_sel` encodings `PC_JUMP`=2'b00, `PC_SEQ`=2'b01, `PC_REG`=2'b10;
  - FSM state encodings;
  - default `RESET_PC`.
- One combinational sub-module `npc_calc`: inputs `pc_plus4`, `order`, `pc_sel`, `br_taken`, `rs_data`; outputs `next_pc` and `misaligned`.
- PC, `order`, FSM, `retired` and `fault` registers live in `inst_fetch`.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `RESET_PC`=0; memory acks in the same cycle; `order_ready`=1; `pc_sel`=01; `br_taken`=0.
  - Required: `im_addr` sequence 0, 4, 8, 12 with one fetch every 2 cycles; `retired`=3 after the third accept.
- Slow memory:
  - Stimulus: ack delayed 3 cycles.
  - Required: `im_addr` and `im_req` stable during the wait; `order_valid` rises one cycle after the ack.
- Branch:
  - Stimulus: `pc`=0x100, `order[15:0]`=16'hFFFE, `pc_sel`=01, `br_taken`=1.
  - Required: next `im_addr`=0xFC.
  - Same instruction with `br_taken`=0: next `im_addr`=0x104.
- Jump and jr:
  - Stimulus: `pc`=0x8000_0010, `pc_sel`=00, `order[25:0]`=26'h0000040.
  - Required: next `im_addr`=0x8000_0100.
  - `pc_sel`=10 with `rs_data`=0x200: next `im_addr`=0x200.
- Stall and fault:
  - Stimulus: hold `order_ready`=0 for 5 cycles.
  - Required: `order` unchanged and no new request during the stall.
  - Then `pc_sel`=10 with `rs_data`=0x202: `fault`=1, `im_req` stays 0, `retired` increments once.
- Wrap and async reset:
  - Stimulus: `pc`=0xFFFF_FFFC, sequential accept.
  - Required: next `im_addr`=0 with `fault`=0.
  - Assert `rst_n` low mid-`REQ`: `im_req` is 0 before the next clock edge.
